// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEFAULT_LINE_SIZE = 128;

    typedef enum logic [1:0] {
        StIdle,
        StGrantI,
        StGrantD
    } arb_state_e;

    typedef enum logic {
        ReqI,
        ReqD
    } req_id_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single line-wide memory port between the icache and dcache.
// Optional performance counters are enabled with `define MEM_ARB_PERF_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned CACHE_LINE_SIZE = DEFAULT_LINE_SIZE,
    parameter int unsigned STARVE_LIMIT    = 8
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       in_icache_read_en,
    input  logic [31:0]                in_icache_addr,
    output logic                       out_icache_ready,
    output logic [CACHE_LINE_SIZE-1:0] out_icache_read_data,

    input  logic                       in_dcache_read_en,
    input  logic                       in_dcache_write_en,
    input  logic [31:0]                in_dcache_addr,
    input  logic [CACHE_LINE_SIZE-1:0] in_dcache_write_data,
    output logic                       out_dcache_ready,
    output logic [CACHE_LINE_SIZE-1:0] out_dcache_read_data,

    output logic                       out_mem_read_en,
    output logic                       out_mem_write_en,
    output logic [31:0]                out_mem_addr,
    output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
    input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
    input  logic                       in_mem_ready
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]                out_icache_grants,
    output logic [31:0]                out_dcache_grants,
    output logic [31:0]                out_icache_wait_cycles
`endif
);

    // Sized so the counter can hold STARVE_LIMIT itself (and is never zero-width).
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

    arb_state_e                 state_q, state_d;
    logic [CntW-1:0]            starve_q, starve_d;
    logic                       mem_rd_q, mem_rd_d;
    logic                       mem_wr_q, mem_wr_d;
    logic [31:0]                mem_addr_q, mem_addr_d;
    logic [CACHE_LINE_SIZE-1:0] mem_wdata_q, mem_wdata_d;

    logic    ireq, dreq;
    logic    grant_valid;
    req_id_e winner;
    logic    idle_grant_i, idle_grant_d;

    assign ireq        = in_icache_read_en;
    assign dreq        = in_dcache_read_en | in_dcache_write_en;
    assign grant_valid = ireq | dreq;
    assign winner      = (ireq && (!dreq || starve_q == StarveMax)) ? ReqI : ReqD;

    assign idle_grant_i = (state_q == StIdle) && grant_valid && (winner == ReqI);
    assign idle_grant_d = (state_q == StIdle) && grant_valid && (winner == ReqD);

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (idle_grant_i) begin
                    state_d     = StGrantI;
                    mem_rd_d    = 1'b1;
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = in_icache_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end else if (idle_grant_d) begin
                    state_d     = StGrantD;
                    // Write-back takes precedence when both enables are raised.
                    mem_wr_d    = in_dcache_write_en;
                    mem_rd_d    = in_dcache_read_en & ~in_dcache_write_en;
                    mem_addr_d  = in_dcache_addr;
                    mem_wdata_d = in_dcache_write_en ? in_dcache_write_data : '0;
                    if (ireq && starve_q != StarveMax) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
                if (!ireq) begin
                    starve_d = '0;
                end
            end
            StGrantI, StGrantD: begin
                if (in_mem_ready) begin
                    state_d     = StIdle;
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign out_mem_read_en    = mem_rd_q;
    assign out_mem_write_en   = mem_wr_q;
    assign out_mem_addr       = mem_addr_q;
    assign out_mem_write_data = mem_wdata_q;

    // Completion is steered only to the current owner; data is zeroed otherwise.
    assign out_icache_ready     = (state_q == StGrantI) && in_mem_ready;
    assign out_dcache_ready     = (state_q == StGrantD) && in_mem_ready;
    assign out_icache_read_data = out_icache_ready ? in_mem_read_data : '0;
    assign out_dcache_read_data = out_dcache_ready ? in_mem_read_data : '0;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] icache_grants_q, dcache_grants_q, icache_wait_q;
    logic        icache_wait;

    // A cycle counts as a stall unless the icache is being granted or already owns memory.
    assign icache_wait = ireq && !idle_grant_i && (state_q != StGrantI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icache_grants_q <= '0;
            dcache_grants_q <= '0;
            icache_wait_q   <= '0;
        end else begin
            if (idle_grant_i) icache_grants_q <= icache_grants_q + 32'd1;
            if (idle_grant_d) dcache_grants_q <= dcache_grants_q + 32'd1;
            if (icache_wait)  icache_wait_q   <= icache_wait_q + 32'd1;
        end
    end

    assign out_icache_grants      = icache_grants_q;
    assign out_dcache_grants      = dcache_grants_q;
    assign out_icache_wait_cycles = icache_wait_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter (STARVE_LIMIT = 2).
module tb_mem_arbiter;

    localparam int unsigned LW = 128;

    logic          clk;
    logic          reset;
    logic          in_icache_read_en;
    logic [31:0]   in_icache_addr;
    logic          out_icache_ready;
    logic [LW-1:0] out_icache_read_data;
    logic          in_dcache_read_en;
    logic          in_dcache_write_en;
    logic [31:0]   in_dcache_addr;
    logic [LW-1:0] in_dcache_write_data;
    logic          out_dcache_ready;
    logic [LW-1:0] out_dcache_read_data;
    logic          out_mem_read_en;
    logic          out_mem_write_en;
    logic [31:0]   out_mem_addr;
    logic [LW-1:0] out_mem_write_data;
    logic [LW-1:0] in_mem_read_data;
    logic          in_mem_ready;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   out_icache_grants;
    logic [31:0]   out_dcache_grants;
    logic [31:0]   out_icache_wait_cycles;
`endif

    mem_arbiter #(
        .CACHE_LINE_SIZE(LW),
        .STARVE_LIMIT   (2)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_icache_read_en     (in_icache_read_en),
        .in_icache_addr        (in_icache_addr),
        .out_icache_ready      (out_icache_ready),
        .out_icache_read_data  (out_icache_read_data),
        .in_dcache_read_en     (in_dcache_read_en),
        .in_dcache_write_en    (in_dcache_write_en),
        .in_dcache_addr        (in_dcache_addr),
        .in_dcache_write_data  (in_dcache_write_data),
        .out_dcache_ready      (out_dcache_ready),
        .out_dcache_read_data  (out_dcache_read_data),
        .out_mem_read_en       (out_mem_read_en),
        .out_mem_write_en      (out_mem_write_en),
        .out_mem_addr          (out_mem_addr),
        .out_mem_write_data    (out_mem_write_data),
        .in_mem_read_data      (in_mem_read_data),
        .in_mem_ready          (in_mem_ready)
`ifdef MEM_ARB_PERF_EN
        ,
        .out_icache_grants     (out_icache_grants),
        .out_dcache_grants     (out_dcache_grants),
        .out_icache_wait_cycles(out_icache_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ir;
        logic [31:0]   ia;
        logic          dr;
        logic          dw;
        logic [31:0]   da;
        logic [LW-1:0] dwd;
        logic          mr;
        logic [LW-1:0] md;
        logic          e_rd;
        logic          e_wr;
        logic [31:0]   e_addr;
        logic [LW-1:0] e_wd;
        logic          e_irdy;
        logic          e_drdy;
        logic [LW-1:0] e_ird;
        logic [LW-1:0] e_drd;
        int            e_starve;
    } vec_t;

    localparam logic          N  = 1'b0;
    localparam logic          Y  = 1'b1;
    localparam logic [LW-1:0] Z  = '0;
    localparam logic [LW-1:0] LA = {16{8'hA5}};
    localparam logic [LW-1:0] L1 = {4{32'h1111_0001}};
    localparam logic [LW-1:0] L2 = {4{32'h2222_0002}};
    localparam logic [LW-1:0] L3 = {4{32'h3333_0003}};
    localparam logic [LW-1:0] L4 = {4{32'h4444_0004}};
    localparam logic [LW-1:0] L5 = {4{32'h5555_0005}};
    localparam logic [LW-1:0] L6 = {4{32'h6666_0006}};
    localparam logic [LW-1:0] L7 = {4{32'h7777_0007}};
    localparam logic [LW-1:0] L8 = {4{32'h8888_0008}};
    localparam logic [LW-1:0] WD = 128'h1234;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [31:0] da, input logic [LW-1:0] dwd,
                                input logic mr, input logic [LW-1:0] md, input logic er,
                                input logic ew, input logic [31:0] ea, input logic [LW-1:0] ewd,
                                input logic eir, input logic edr, input int es);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.mr = mr; v.md = md;
        v.e_rd = er; v.e_wr = ew; v.e_addr = ea; v.e_wd = ewd;
        v.e_irdy = eir; v.e_drdy = edr;
        v.e_ird = eir ? md : Z;
        v.e_drd = edr ? md : Z;
        v.e_starve = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_icache_read_en    = v.ir;
        in_icache_addr       = v.ia;
        in_dcache_read_en    = v.dr;
        in_dcache_write_en   = v.dw;
        in_dcache_addr       = v.da;
        in_dcache_write_data = v.dwd;
        in_mem_ready         = v.mr;
        in_mem_read_data     = v.md;
    endtask

    initial begin
        vec_t idle;
        idle = mk(N, 32'h0, N, N, 32'h0, Z, N, Z, N, N, 32'h0, Z, N, N, -1);

        // mem_ready while idle must be ignored
        vecs.push_back(mk(N, 32'h0, N, N, 32'h0, Z, Y, LA, N, N, 32'h0, Z, N, N, 0));
        // icache-only fill, memory ready after 3 wait cycles
        vecs.push_back(mk(Y, 32'h100, N, N, 32'h0, Z, N, Z, N, N, 32'h0, Z, N, N, 0));
        vecs.push_back(mk(Y, 32'h100, N, N, 32'h0, Z, N, Z, Y, N, 32'h100, Z, N, N, 0));
        vecs.push_back(mk(Y, 32'h100, N, N, 32'h0, Z, N, Z, Y, N, 32'h100, Z, N, N, -1));
        vecs.push_back(mk(Y, 32'h100, N, N, 32'h0, Z, N, Z, Y, N, 32'h100, Z, N, N, -1));
        vecs.push_back(mk(Y, 32'h100, N, N, 32'h0, Z, Y, LA, Y, N, 32'h100, Z, Y, N, -1));
        vecs.push_back(idle);
        // simultaneous requests: dcache first, icache after one idle cycle
        vecs.push_back(mk(Y, 32'h200, Y, N, 32'h300, Z, N, Z, N, N, 32'h0, Z, N, N, 0));
        vecs.push_back(mk(Y, 32'h200, Y, N, 32'h300, Z, N, Z, Y, N, 32'h300, Z, N, N, 1));
        vecs.push_back(mk(Y, 32'h200, Y, N, 32'h300, Z, Y, L1, Y, N, 32'h300, Z, N, Y, 1));
        vecs.push_back(mk(Y, 32'h200, N, N, 32'h0, Z, N, Z, N, N, 32'h0, Z, N, N, 1));
        vecs.push_back(mk(Y, 32'h200, N, N, 32'h0, Z, N, Z, Y, N, 32'h200, Z, N, N, 0));
        vecs.push_back(mk(Y, 32'h200, N, N, 32'h0, Z, Y, L2, Y, N, 32'h200, Z, Y, N, 0));
        vecs.push_back(idle);
        // read+write together: write wins; then immediate fill at 0x80
        vecs.push_back(mk(N, 32'h0, Y, Y, 32'h40, WD, N, Z, N, N, 32'h0, Z, N, N, -1));
        vecs.push_back(mk(N, 32'h0, Y, Y, 32'h40, WD, N, Z, N, Y, 32'h40, WD, N, N, -1));
        vecs.push_back(mk(N, 32'h0, Y, Y, 32'h40, WD, Y, L3, N, Y, 32'h40, WD, N, Y, -1));
        vecs.push_back(mk(N, 32'h0, Y, N, 32'h80, Z, N, Z, N, N, 32'h0, Z, N, N, -1));
        vecs.push_back(mk(N, 32'h0, Y, N, 32'h80, Z, N, Z, Y, N, 32'h80, Z, N, N, -1));
        vecs.push_back(mk(N, 32'h0, Y, N, 32'h80, Z, Y, L4, Y, N, 32'h80, Z, N, Y, -1));
        vecs.push_back(mk(N, 32'h0, N, N, 32'h0, Z, N, Z, N, N, 32'h0, Z, N, N, 0));
        // starvation: icache held high, dcache back-to-back, icache wins 3rd round
        vecs.push_back(mk(Y, 32'h700, Y, N, 32'h800, Z, N, Z, N, N, 32'h0, Z, N, N, 0));
        vecs.push_back(mk(Y, 32'h700, Y, N, 32'h800, Z, N, Z, Y, N, 32'h800, Z, N, N, 1));
        vecs.push_back(mk(Y, 32'h700, Y, N, 32'h800, Z, Y, L5, Y, N, 32'h800, Z, N, Y, 1));
        vecs.push_back(mk(Y, 32'h700, Y, N, 32'h900, Z, N, Z, N, N, 32'h0, Z, N, N, 1));
        vecs.push_back(mk(Y, 32'h700, Y, N, 32'h900, Z, N, Z, Y, N, 32'h900, Z, N, N, 2));
        vecs.push_back(mk(Y, 32'h700, Y, N, 32'h900, Z, Y, L6, Y, N, 32'h900, Z, N, Y, 2));
        vecs.push_back(mk(Y, 32'h700, Y, N, 32'hA00, Z, N, Z, N, N, 32'h0, Z, N, N, 2));
        vecs.push_back(mk(Y, 32'h700, Y, N, 32'hA00, Z, N, Z, Y, N, 32'h700, Z, N, N, 0));
        vecs.push_back(mk(Y, 32'h700, Y, N, 32'hA00, Z, Y, L7, Y, N, 32'h700, Z, Y, N, 0));
        vecs.push_back(mk(N, 32'h0, Y, N, 32'hA00, Z, N, Z, N, N, 32'h0, Z, N, N, 0));
        vecs.push_back(mk(N, 32'h0, Y, N, 32'hA00, Z, N, Z, Y, N, 32'hA00, Z, N, N, 0));
        vecs.push_back(mk(N, 32'h0, Y, N, 32'hA00, Z, Y, L8, Y, N, 32'hA00, Z, N, Y, 0));
        vecs.push_back(mk(N, 32'h0, N, N, 32'h0, Z, N, Z, N, N, 32'h0, Z, N, N, 0));

        reset = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset mem_read_en", out_mem_read_en, N);
        check("reset mem_write_en", out_mem_write_en, N);
        check("reset mem_addr", out_mem_addr, 32'h0);
        check("reset icache_ready", out_icache_ready, N);
        check("reset dcache_ready", out_dcache_ready, N);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d mem_read_en", i), out_mem_read_en, vecs[i].e_rd);
            check($sformatf("v%0d mem_write_en", i), out_mem_write_en, vecs[i].e_wr);
            check($sformatf("v%0d mem_addr", i), out_mem_addr, vecs[i].e_addr);
            check($sformatf("v%0d mem_write_data", i), out_mem_write_data, vecs[i].e_wd);
            check($sformatf("v%0d icache_ready", i), out_icache_ready, vecs[i].e_irdy);
            check($sformatf("v%0d dcache_ready", i), out_dcache_ready, vecs[i].e_drdy);
            check($sformatf("v%0d icache_data", i), out_icache_read_data, vecs[i].e_ird);
            check($sformatf("v%0d dcache_data", i), out_dcache_read_data, vecs[i].e_drd);
            if (vecs[i].e_starve >= 0) begin
                check($sformatf("v%0d starve_cnt", i), 128'(dut.starve_q),
                      128'(vecs[i].e_starve));
            end
            @(posedge clk);
            #1;
        end

        // reset in the middle of a dcache grant, before memory answers
        in_dcache_read_en = 1'b1;
        in_dcache_addr    = 32'h500;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pre-reset mem_read_en", out_mem_read_en, Y);
        check("pre-reset mem_addr", out_mem_addr, 32'h500);
        #1;
        reset            = 1'b0;
        in_mem_ready     = 1'b1;
        in_mem_read_data = L1;
        #1;
        check("mid reset mem_read_en", out_mem_read_en, N);
        check("mid reset mem_write_en", out_mem_write_en, N);
        check("mid reset mem_addr", out_mem_addr, 32'h0);
        check("mid reset icache_ready", out_icache_ready, N);
        check("mid reset dcache_ready", out_dcache_ready, N);
        check("mid reset dcache_data", out_dcache_read_data, Z);
        drive(idle);
        @(posedge clk);
        #1 reset = 1'b1;
        in_icache_read_en = 1'b1;
        in_icache_addr    = 32'h600;
        @(negedge clk);
        check("post-reset idle read_en", out_mem_read_en, N);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post-reset mem_read_en", out_mem_read_en, Y);
        check("post-reset mem_addr", out_mem_addr, 32'h600);
        in_mem_ready     = 1'b1;
        in_mem_read_data = LA;
        #1;
        check("post-reset icache_ready", out_icache_ready, Y);
        check("post-reset icache_data", out_icache_read_data, LA);
        check("post-reset dcache_ready", out_dcache_ready, N);
        @(posedge clk);
        #1 drive(idle);
        @(negedge clk);
        check("final mem_read_en", out_mem_read_en, N);
`ifdef MEM_ARB_PERF_EN
        check("perf icache_grants", out_icache_grants, 32'd1);
        check("perf dcache_grants", out_dcache_grants, 32'd0);
        check("perf icache_wait", out_icache_wait_cycles, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
